fpga_reset_sequencer: RTL and testbench
=======================================

FPGA_RESET_SEQUENCER -- requirements
Module: fpga_reset_sequencer

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth (minimum 2).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1250000, button stability window (10 ms at 125 MHz; minimum 1).
REQ-003 SHALL have parameter HOLD_CYCLES, default 1024, reset stretch after lock (minimum 1).
REQ-004 SHALL have port clk_i, input, 1, the single clock: 125 MHz BUFG output feeding the SoC.
REQ-005 SHALL have port rst_i, input, 1; reset is synchronous and active-high.
REQ-006 SHALL have port btn_reset_i, input, 1, raw asynchronous board reset button, active-high.
REQ-007 SHALL have port mmcm_locked_i, input, 1, asynchronous MMCM LOCKED.
REQ-008 SHALL have port soc_rst_no, output, 1, active-low reset to the SoC pad_reset_n.
REQ-009 SHALL have port jtag_trst_no, output, 1, active-low JTAG TAP reset.
REQ-010 SHALL have port reset_cause_o, output, 2: 00 power-on, 01 button, 10 lock loss.
REQ-011 SHALL have port reset_count_o, output, 8, saturating count of sequencer-triggered resets.

Function
REQ-012 SHALL pass btn_reset_i and mmcm_locked_i each through a SYNC_STAGES flop chain before any use (btn_s, lock_s).
REQ-013 SHALL debounce btn_s: counter clears when btn_s equals debounced value btn_d; otherwise increments; btn_d toggles and counter clears when counter equals DEBOUNCE_CYCLES-1.
REQ-014 SHALL implement states HOLD, WAIT_LOCK, STRETCH, RUN.
REQ-015 HOLD -> WAIT_LOCK when btn_d is 0; HOLD is kept while btn_d is 1.
REQ-016 WAIT_LOCK -> STRETCH, with the stretch counter cleared to 0, when lock_s is 1.
REQ-017 STRETCH: counter increments each cycle; -> RUN on the cycle after the counter equals HOLD_CYCLES-1, so STRETCH lasts exactly HOLD_CYCLES cycles.
REQ-018 From STRETCH or RUN, lock_s = 0 SHALL go -> HOLD with cause 10.
REQ-019 From any state except HOLD, btn_d = 1 SHALL go -> HOLD with cause 01; if lock loss and button occur in the same cycle, cause SHALL be 10.
REQ-020 Lock low in WAIT_LOCK SHALL NOT count as a lock-loss event.
REQ-021 Every entry into HOLD other than by rst_i SHALL increment reset_count_o, saturating at 255.
REQ-022 All outputs SHALL be registered and updated on the same edge as the state register.
REQ-023 jtag_trst_no SHALL be 0 in HOLD and WAIT_LOCK, and 1 in STRETCH and RUN.
REQ-024 soc_rst_no SHALL be 1 only in RUN.
REQ-025 reset_cause_o SHALL hold its value until the next HOLD entry.
REQ-026 From rst_i deassertion with btn low and lock high, soc_rst_no SHALL rise exactly SYNC_STAGES+1+HOLD_CYCLES edges later.

Reset
REQ-027 On rst_i: state HOLD, synchronizers 0, btn_d 0, counters 0, soc_rst_no 0, jtag_trst_no 0, reset_cause_o 00, reset_count_o 0.
REQ-028 rst_i asserted mid-sequence SHALL override all transitions in that cycle.

Structure
REQ-029 Package fpga_rst_pkg SHALL hold the state enum, the cause enum (2-bit), and the counter width function.
REQ-030 Sub-module fpga_sync_bit (SYNC_STAGES-deep synchronizer) SHALL be instantiated twice; the debouncer and FSM stay in the top module.

Verification (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=8)
REQ-031 rst_i released with lock=1 and btn=0 -> jtag_trst_no rises at edge 3 and soc_rst_no rises at edge 11; cause=00; count=0.
REQ-032 btn pulse of 3 cycles while in RUN -> soc_rst_no stays 1 and count stays 0.
REQ-033 btn held 20 cycles while in RUN -> soc_rst_no falls within 7 cycles; cause=01; count=1; after release and debounce, the resequence takes 8 STRETCH cycles.
REQ-034 lock dropped 3 cycles during STRETCH -> HOLD, cause=10, stretch counter restarts from 0 after relock.
REQ-035 btn_d rising in the same cycle lock_s falls in RUN -> cause=10 and count increments by exactly 1.
REQ-036 300 button resets -> reset_count_o saturates at 255; a subsequent rst_i pulse -> 0.

Source files
------------

// File: rtl/fpga_rst_pkg.sv
// Shared types for the board reset sequencer: FSM states, reset-cause encoding, counter sizing.
package fpga_rst_pkg;

  typedef enum logic [1:0] {
    ST_HOLD      = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STRETCH   = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_POR       = 2'b00,
    CAUSE_BUTTON    = 2'b01,
    CAUSE_LOCK_LOSS = 2'b10
  } cause_t;

  localparam logic [7:0] RESET_COUNT_MAX = 8'hFF;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fpga_reset_sequencer_if.sv
// Board-side reset bundle: raw button/lock inputs and the generated resets plus status.
interface fpga_reset_sequencer_if;
  logic       btn_reset;
  logic       mmcm_locked;
  logic       soc_rst_n;
  logic       jtag_trst_n;
  logic [1:0] reset_cause;
  logic [7:0] reset_count;

  modport master (
    output btn_reset, mmcm_locked,
    input  soc_rst_n, jtag_trst_n, reset_cause, reset_count
  );

  modport slave (
    input  btn_reset, mmcm_locked,
    output soc_rst_n, jtag_trst_n, reset_cause, reset_count
  );
endinterface

// File: rtl/fpga_sync_bit.sv
// Single-bit STAGES-deep flop synchronizer, cleared by the synchronous reset.
// Latency STAGES cycles; no backpressure.
module fpga_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk_i) begin
    if (rst_i) chain <= '0;
    else       chain <= {chain[STAGES-2:0], d_i};
  end

  assign q_o = chain[STAGES-1];

endmodule

// File: rtl/fpga_reset_sequencer.sv
// Board reset sequencer: debounced button + MMCM lock drive JTAG and SoC resets with a post-lock stretch.
// All outputs registered on the state edge; soc_rst_no rises SYNC_STAGES+1+HOLD_CYCLES edges after a clean release.
module fpga_reset_sequencer
  import fpga_rst_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1250000,
  parameter int HOLD_CYCLES     = 1024
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       btn_reset_i,
  input  logic       mmcm_locked_i,
  output logic       soc_rst_no,
  output logic       jtag_trst_no,
  output logic [1:0] reset_cause_o,
  output logic [7:0] reset_count_o
);

  localparam int DB_W = cnt_width(DEBOUNCE_CYCLES);
  localparam int ST_W = cnt_width(HOLD_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(HOLD_CYCLES - 1);

  logic            btn_s, lock_s, btn_d;
  logic [DB_W-1:0] db_cnt;
  logic [ST_W-1:0] st_cnt;
  state_t          state;
  cause_t          cause_r;
  logic            go_hold;
  cause_t          go_cause;

  fpga_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_btn (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (btn_reset_i),
    .q_o   (btn_s)
  );

  fpga_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_lock (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (mmcm_locked_i),
    .q_o   (lock_s)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      btn_d  <= 1'b0;
      db_cnt <= '0;
    end else if (btn_s == btn_d) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      btn_d  <= ~btn_d;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

  // Lock loss outranks the button; lock low while still waiting for lock is not an event.
  always_comb begin
    go_hold  = 1'b0;
    go_cause = CAUSE_BUTTON;
    if ((state == ST_STRETCH || state == ST_RUN) && !lock_s) begin
      go_hold  = 1'b1;
      go_cause = CAUSE_LOCK_LOSS;
    end else if (state != ST_HOLD && btn_d) begin
      go_hold  = 1'b1;
      go_cause = CAUSE_BUTTON;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= ST_HOLD;
      st_cnt        <= '0;
      soc_rst_no    <= 1'b0;
      jtag_trst_no  <= 1'b0;
      cause_r       <= CAUSE_POR;
      reset_count_o <= '0;
    end else if (go_hold) begin
      state        <= ST_HOLD;
      soc_rst_no   <= 1'b0;
      jtag_trst_no <= 1'b0;
      cause_r      <= go_cause;
      if (reset_count_o != RESET_COUNT_MAX) reset_count_o <= reset_count_o + 8'd1;
    end else begin
      case (state)
        ST_HOLD: begin
          if (!btn_d) state <= ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state        <= ST_STRETCH;
            st_cnt       <= '0;
            jtag_trst_no <= 1'b1;
          end
        end
        ST_STRETCH: begin
          if (st_cnt == ST_LAST) begin
            state      <= ST_RUN;
            soc_rst_no <= 1'b1;
          end else begin
            st_cnt <= st_cnt + ST_W'(1);
          end
        end
        ST_RUN: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

  assign reset_cause_o = cause_r;

endmodule

// File: tb/tb_fpga_reset_sequencer.sv
// Scoreboarded directed bench for fpga_reset_sequencer (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=8).
module tb_fpga_reset_sequencer;

  typedef struct {
    string      name;
    int         cyc;
    logic       soc;
    logic       jtag;
    logic [1:0] cause;
    logic [7:0] count;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   failed = 0;
  exp_t sb[$];
  exp_t mon_e;
  exp_t end_e;

  fpga_reset_sequencer_if bif();

  fpga_reset_sequencer #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (8)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .btn_reset_i   (bif.btn_reset),
    .mmcm_locked_i (bif.mmcm_locked),
    .soc_rst_no    (bif.soc_rst_n),
    .jtag_trst_no  (bif.jtag_trst_n),
    .reset_cause_o (bif.reset_cause),
    .reset_count_o (bif.reset_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops every expectation whose cycle has arrived and compares away from the edge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      tests++;
      if (mon_e.cyc != cyc || bif.soc_rst_n !== mon_e.soc || bif.jtag_trst_n !== mon_e.jtag ||
          bif.reset_cause !== mon_e.cause || bif.reset_count !== mon_e.count) begin
        failed++;
        $display("FAIL %s @cyc %0d (due %0d): got soc=%b jtag=%b cause=%b count=%0d, want soc=%b jtag=%b cause=%b count=%0d",
                 mon_e.name, cyc, mon_e.cyc, bif.soc_rst_n, bif.jtag_trst_n, bif.reset_cause,
                 bif.reset_count, mon_e.soc, mon_e.jtag, mon_e.cause, mon_e.count);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string nm, input int off, input logic soc, input logic jtag,
                          input logic [1:0] cause, input logic [7:0] count);
    sb.push_back('{nm, cyc + off, soc, jtag, cause, count});
  endtask

  initial begin
    int cnt;
    bif.btn_reset   = 1'b0;
    bif.mmcm_locked = 1'b1;
    rst             = 1'b1;
    tick(3);

    // Power-on release: jtag at edge 3, soc at edge 11.
    push_exp("reset_state", 0, 1'b0, 1'b0, 2'b00, 8'd0);
    rst = 1'b0;
    push_exp("por_jtag_low", 2, 1'b0, 1'b0, 2'b00, 8'd0);
    push_exp("por_jtag_rise", 3, 1'b0, 1'b1, 2'b00, 8'd0);
    push_exp("por_soc_low", 10, 1'b0, 1'b1, 2'b00, 8'd0);
    push_exp("por_soc_rise", 11, 1'b1, 1'b1, 2'b00, 8'd0);
    tick(11);

    // Short 3-cycle glitch is filtered out.
    for (int i = 1; i <= 12; i++) push_exp("btn_glitch", i, 1'b1, 1'b1, 2'b00, 8'd0);
    bif.btn_reset = 1'b1;
    tick(3);
    bif.btn_reset = 1'b0;
    tick(9);

    // Button held 20 cycles: reset after 7 edges, then a full 8-cycle restretch.
    push_exp("btn_pre", 6, 1'b1, 1'b1, 2'b00, 8'd0);
    push_exp("btn_fall", 7, 1'b0, 1'b0, 2'b01, 8'd1);
    push_exp("btn_hold", 26, 1'b0, 1'b0, 2'b01, 8'd1);
    push_exp("btn_wait", 27, 1'b0, 1'b0, 2'b01, 8'd1);
    push_exp("btn_stretch", 28, 1'b0, 1'b1, 2'b01, 8'd1);
    push_exp("btn_stretch_end", 35, 1'b0, 1'b1, 2'b01, 8'd1);
    push_exp("btn_run", 36, 1'b1, 1'b1, 2'b01, 8'd1);
    bif.btn_reset = 1'b1;
    tick(20);
    bif.btn_reset = 1'b0;
    tick(16);

    // Lock loss in RUN, then again during STRETCH; stretch restarts from zero.
    push_exp("lock_pre", 2, 1'b1, 1'b1, 2'b01, 8'd1);
    push_exp("lock_run_loss", 3, 1'b0, 1'b0, 2'b10, 8'd2);
    push_exp("lock_wait_low", 5, 1'b0, 1'b0, 2'b10, 8'd2);
    push_exp("lock_stretch1", 6, 1'b0, 1'b1, 2'b10, 8'd2);
    push_exp("lock_stretch1b", 10, 1'b0, 1'b1, 2'b10, 8'd2);
    push_exp("lock_stretch_loss", 11, 1'b0, 1'b0, 2'b10, 8'd3);
    push_exp("lock_wait2", 13, 1'b0, 1'b0, 2'b10, 8'd3);
    push_exp("lock_stretch2", 14, 1'b0, 1'b1, 2'b10, 8'd3);
    push_exp("lock_stretch2_end", 21, 1'b0, 1'b1, 2'b10, 8'd3);
    push_exp("lock_run", 22, 1'b1, 1'b1, 2'b10, 8'd3);
    bif.mmcm_locked = 1'b0;
    tick(3);
    bif.mmcm_locked = 1'b1;
    tick(5);
    bif.mmcm_locked = 1'b0;
    tick(3);
    bif.mmcm_locked = 1'b1;
    tick(11);

    // Button and lock loss land on the same cycle: lock loss wins, counted once.
    push_exp("both_pre", 6, 1'b1, 1'b1, 2'b10, 8'd3);
    push_exp("both_hold", 7, 1'b0, 1'b0, 2'b10, 8'd4);
    push_exp("both_once", 12, 1'b0, 1'b0, 2'b10, 8'd4);
    push_exp("both_wait", 17, 1'b0, 1'b0, 2'b10, 8'd4);
    push_exp("both_stretch", 18, 1'b0, 1'b1, 2'b10, 8'd4);
    push_exp("both_stretch_end", 25, 1'b0, 1'b1, 2'b10, 8'd4);
    push_exp("both_run", 26, 1'b1, 1'b1, 2'b10, 8'd4);
    bif.btn_reset = 1'b1;
    tick(4);
    bif.mmcm_locked = 1'b0;
    tick(6);
    bif.btn_reset   = 1'b0;
    bif.mmcm_locked = 1'b1;
    tick(16);

    // 300 button resets: counter saturates at 255.
    for (int i = 0; i < 300; i++) begin
      cnt = (4 + i + 1 > 255) ? 255 : 4 + i + 1;
      push_exp("btn_sat", 8, 1'b0, 1'b0, 2'b01, 8'(cnt));
      bif.btn_reset = 1'b1;
      tick(8);
      bif.btn_reset = 1'b0;
      tick(8);
    end
    push_exp("sat_final", 4, 1'b0, 1'b1, 2'b01, 8'd255);
    tick(5);

    // Mid-sequence rst_i clears everything and resequences from scratch.
    rst = 1'b1;
    tick(1);
    push_exp("rst_clear", 0, 1'b0, 1'b0, 2'b00, 8'd0);
    rst = 1'b0;
    push_exp("rst_jtag_low", 2, 1'b0, 1'b0, 2'b00, 8'd0);
    push_exp("rst_jtag_rise", 3, 1'b0, 1'b1, 2'b00, 8'd0);
    push_exp("rst_soc_low", 10, 1'b0, 1'b1, 2'b00, 8'd0);
    push_exp("rst_soc_rise", 11, 1'b1, 1'b1, 2'b00, 8'd0);
    tick(14);

    tests++;
    if (bif.soc_rst_n !== 1'b1) begin
        failed++;
        $display("FAIL final_soc: got soc=%b, want 1", bif.soc_rst_n);
    end
    tests++;
    if (bif.jtag_trst_n !== 1'b1) begin
        failed++;
        $display("FAIL final_jtag: got jtag=%b, want 1", bif.jtag_trst_n);
    end
    tests++;
    if (bif.reset_cause !== 2'b00) begin
        failed++;
        $display("FAIL final_cause: got cause=%b, want 00", bif.reset_cause);
    end
    tests++;
    if (bif.reset_count !== 8'd0) begin
        failed++;
        $display("FAIL final_count: got count=%0d, want 0", bif.reset_count);
    end

    while (sb.size() > 0) begin
      end_e = sb.pop_front();
      tests++;
      failed++;
      $display("FAIL %s: expectation due at cyc %0d never checked, run ended at cyc %0d",
               end_e.name, end_e.cyc, cyc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
